// File: rtl/inst_seq_ctrl_pkg.sv
// rtl/inst_seq_ctrl_pkg.sv - shared state encodings and defaults for the instruction sequencer
package inst_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PAUSE     = 3'd1,
    ST_FETCH     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5,
    ST_HALTED    = 3'd6,
    ST_ERR       = 3'd7
  } seq_state_t;

  // Word that terminates a program; it is fetched but never issued.
  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

  // Fetch wait counter only has to reach MEM_LAT (at most 3).
  localparam int FETCH_CNT_W = 2;

  // States in which the sequencer is parked and accepts a start pulse.
  function automatic logic is_parked(input seq_state_t s);
    return (s == ST_IDLE) || (s == ST_HALTED) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/inst_seq_ctrl_cycle_timer.sv
// rtl/inst_seq_ctrl_cycle_timer.sv - clearable up-counter that stops at a terminal count
module cycle_timer #(
  parameter int W    = 4,
  parameter int TERM = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count;

  assign tc = (count == W'(TERM));

  // Count enabled cycles from zero; hold once the terminal value is reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/inst_seq_ctrl.sv
// rtl/inst_seq_ctrl.sv - walks instruction memory, issues each word with a run pulse, waits for done
module inst_seq_ctrl
  import inst_seq_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 16,
  parameter int                MEM_LAT   = 1,
  parameter int                TIMEOUT   = 15,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEFAULT),
  parameter int                WRAP      = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W:0]   instr_count
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = '1;

  seq_state_t state;
  seq_state_t state_nx;
  logic       fetch_tc;
  logic       wait_tc;
  logic       fetch_clr;
  logic       wait_clr;
  logic       wait_en;

  // Fetch timer runs only while in FETCH; its terminal count marks the last fetch edge.
  assign fetch_clr = (state != ST_FETCH);

  // Timeout timer is zero on entry to WAIT_DONE and advances on each cycle without done.
  assign wait_clr = (state != ST_WAIT_DONE);
  assign wait_en  = !done;

  cycle_timer #(
    .W    (FETCH_CNT_W),
    .TERM (MEM_LAT)
  ) u_fetch_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (fetch_clr),
    .en      (1'b1),
    .tc      (fetch_tc)
  );

  cycle_timer #(
    .W    (TIMER_W),
    .TERM (TIMEOUT - 1)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .tc      (wait_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; done is checked before the timeout so a coincident done wins.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_HALTED, ST_ERR: begin
        if (start) state_nx = step_mode ? ST_PAUSE : ST_FETCH;
      end
      ST_PAUSE: begin
        if (step) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_tc) state_nx = (mem_q == HALT_WORD) ? ST_HALTED : ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nx = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done)         state_nx = ST_NEXT;
        else if (wait_tc) state_nx = ST_ERR;
      end
      ST_NEXT: begin
        if ((mem_addr != ADDR_LAST) || (WRAP != 0)) state_nx = step_mode ? ST_PAUSE : ST_FETCH;
        else                                        state_nx = ST_HALTED;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Address, instruction latch and completion counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr    <= '0;
      din         <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED, ST_ERR: begin
          if (start) begin
            mem_addr    <= '0;
            instr_count <= '0;
          end
        end
        ST_FETCH: begin
          if (fetch_tc) din <= mem_q;
        end
        ST_WAIT_DONE: begin
          if (done && (instr_count != COUNT_MAX)) instr_count <= instr_count + 1'b1;
        end
        ST_NEXT: begin
          if (mem_addr != ADDR_LAST) mem_addr <= mem_addr + 1'b1;
          else if (WRAP != 0)        mem_addr <= '0;
        end
        default: ;
      endcase
    end
  end

  assign run    = (state == ST_ISSUE);
  assign busy   = !is_parked(state);
  assign halted = (state == ST_HALTED);
  assign error  = (state == ST_ERR);

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// tb/tb_inst_seq_ctrl.sv - self-checking bench for inst_seq_ctrl (WRAP=0 and WRAP=1 instances)
module tb_inst_seq_ctrl;
  import inst_seq_ctrl_pkg::*;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 1;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 32;

  // Model phases (bench-private numbering).
  localparam int PH_PARK_IDLE = 10;
  localparam int PH_PARK_HALT = 11;
  localparam int PH_PARK_ERR  = 12;
  localparam int PH_PAUSE     = 20;
  localparam int PH_FETCH     = 21;
  localparam int PH_ISSUE     = 22;
  localparam int PH_WAIT      = 23;
  localparam int PH_ADV       = 24;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic start     = 1'b0;
  logic step_mode = 1'b0;
  logic step      = 1'b0;
  logic done [2]  = '{1'b0, 1'b0};

  logic [ADDR_W-1:0] mem_addr_o [2];
  logic [DATA_W-1:0] mem_q      [2];
  logic [DATA_W-1:0] din_o      [2];
  logic              run_o      [2];
  logic              busy_o     [2];
  logic              halted_o   [2];
  logic              error_o    [2];
  logic [ADDR_W:0]   icnt_o     [2];

  logic [DATA_W-1:0] mem [DEPTH];

  int errs   = 0;
  int checks = 0;

  int ph [2];
  int left [2];
  int waited [2];
  int m_addr [2];
  int m_cnt [2];
  logic [DATA_W-1:0] m_din [2];

  int done_delay = 3;
  int since [2] = '{0, 0};
  bit act [2] = '{1'b0, 1'b0};

  int ncyc = 0;
  int runs0 = 0;
  int runs1 = 0;
  logic [DATA_W-1:0] last_din1 = '0;
  logic [DATA_W-1:0] runlog0 [$];
  int last_run_n = 0;
  int err_n = 0;
  bit err_seen = 1'b0;

  assign mem_q[0] = mem[mem_addr_o[0]];
  assign mem_q[1] = mem[mem_addr_o[1]];

  always #5 clk = ~clk;

  inst_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT), .WRAP(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .step_mode(step_mode), .step(step),
    .mem_addr(mem_addr_o[0]), .mem_q(mem_q[0]), .din(din_o[0]), .run(run_o[0]), .done(done[0]),
    .busy(busy_o[0]), .halted(halted_o[0]), .error(error_o[0]), .instr_count(icnt_o[0])
  );

  inst_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT), .WRAP(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .step_mode(step_mode), .step(step),
    .mem_addr(mem_addr_o[1]), .mem_q(mem_q[1]), .din(din_o[1]), .run(run_o[1]), .done(done[1]),
    .busy(busy_o[1]), .halted(halted_o[1]), .error(error_o[1]), .instr_count(icnt_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act_v, exp_v, $time);
    end
  endtask

  function automatic bit m_parked(input int p);
    return (p == PH_PARK_IDLE) || (p == PH_PARK_HALT) || (p == PH_PARK_ERR);
  endfunction

  task automatic model_reset(input int i);
    ph[i] = PH_PARK_IDLE; left[i] = 0; waited[i] = 0;
    m_addr[i] = 0; m_cnt[i] = 0; m_din[i] = '0;
  endtask

  task automatic model_begin(input int i);
    if (step_mode) ph[i] = PH_PAUSE;
    else begin ph[i] = PH_FETCH; left[i] = MEM_LAT + 1; end
  endtask

  // One clock of the sequencer rules, with the WRAP=1 behaviour on instance 1.
  task automatic model_step(input int i);
    case (ph[i])
      PH_PARK_IDLE, PH_PARK_HALT, PH_PARK_ERR:
        if (start) begin m_addr[i] = 0; m_cnt[i] = 0; model_begin(i); end
      PH_PAUSE:
        if (step) begin ph[i] = PH_FETCH; left[i] = MEM_LAT + 1; end
      PH_FETCH: begin
        left[i]--;
        if (left[i] == 0) begin
          m_din[i] = mem[m_addr[i]];
          ph[i] = (m_din[i] == HALT_WORD_DEFAULT) ? PH_PARK_HALT : PH_ISSUE;
        end
      end
      PH_ISSUE: begin ph[i] = PH_WAIT; waited[i] = 0; end
      PH_WAIT: begin
        if (done[i]) begin
          m_cnt[i] = (m_cnt[i] < 63) ? m_cnt[i] + 1 : 63;
          ph[i] = PH_ADV;
        end else begin
          waited[i]++;
          if (waited[i] == TIMEOUT) ph[i] = PH_PARK_ERR;
        end
      end
      PH_ADV: begin
        if (m_addr[i] < DEPTH - 1) begin m_addr[i]++; model_begin(i); end
        else if (i == 1) begin m_addr[i] = 0; model_begin(i); end
        else ph[i] = PH_PARK_HALT;
      end
      default: ph[i] = PH_PARK_IDLE;
    endcase
  endtask

  // Model advances on the same edges as the DUTs and resets with them.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) model_reset(i);
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Mid-cycle: compare both DUTs to the model, log runs, then drive the done responders.
  always @(negedge clk) begin
    ncyc++;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cmp%0d_run", i),    {31'd0, run_o[i]},    {31'd0, ph[i] == PH_ISSUE});
      chk($sformatf("cmp%0d_busy", i),   {31'd0, busy_o[i]},   {31'd0, !m_parked(ph[i])});
      chk($sformatf("cmp%0d_halted", i), {31'd0, halted_o[i]}, {31'd0, ph[i] == PH_PARK_HALT});
      chk($sformatf("cmp%0d_error", i),  {31'd0, error_o[i]},  {31'd0, ph[i] == PH_PARK_ERR});
      chk($sformatf("cmp%0d_addr", i),   32'(mem_addr_o[i]),   32'(m_addr[i]));
      chk($sformatf("cmp%0d_din", i),    32'(din_o[i]),        32'(m_din[i]));
      chk($sformatf("cmp%0d_count", i),  32'(icnt_o[i]),       32'(m_cnt[i]));
    end
    if (run_o[0] === 1'b1) begin runs0++; runlog0.push_back(din_o[0]); last_run_n = ncyc; end
    if (run_o[1] === 1'b1) begin runs1++; last_din1 = din_o[1]; end
    if (error_o[0] === 1'b1 && !err_seen) begin err_seen = 1'b1; err_n = ncyc; end
    if (error_o[0] !== 1'b1) err_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      done[i] = 1'b0;
      if (!reset_n) act[i] = 1'b0;
      if (act[i]) begin
        since[i]++;
        if (done_delay != 0 && since[i] == done_delay) begin done[i] = 1'b1; act[i] = 1'b0; end
      end
      if (run_o[i] === 1'b1) begin act[i] = 1'b1; since[i] = 0; end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; cyc(1); step = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy_o[0] && n < budget) begin cyc(1); n++; end
    checks++;
    if (busy_o[0]) begin errs++; $display("FAIL %s: still busy after %0d cycles", nm, budget); end
  endtask

  task automatic load_prog();
    for (int k = 0; k < DEPTH; k++) mem[k] = 16'h0100 + 16'(k);
    mem[0] = 16'h0041; mem[1] = 16'h0082; mem[2] = HALT_WORD_DEFAULT;
  endtask

  initial begin
    int n;
    load_prog();
    cyc(3);
    chk("reset_addr", 32'(mem_addr_o[0]), 32'd0);
    chk("reset_busy", {31'd0, busy_o[0]}, 32'd0);
    chk("reset_count", 32'(icnt_o[0]), 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // Run to halt: two instructions then the halt word.
    done_delay = 3; runlog0.delete(); runs0 = 0;
    pulse_start();
    wait_idle("t1_idle", 200);
    chk("t1_runs", 32'(runs0), 32'd2);
    chk("t1_din0", 32'(runlog0[0]), 32'h0041);
    chk("t1_din1", 32'(runlog0[1]), 32'h0082);
    chk("t1_halted", {31'd0, halted_o[0]}, 32'd1);
    chk("t1_count", 32'(icnt_o[0]), 32'd2);
    chk("t1_addr", 32'(mem_addr_o[0]), 32'd2);
    chk("t1_error", {31'd0, error_o[0]}, 32'd0);

    // Timeout: run cycle, 15 waiting cycles, then ERR.
    done_delay = 0; runs0 = 0;
    pulse_start();
    wait_idle("t2_idle", 100);
    chk("t2_error", {31'd0, error_o[0]}, 32'd1);
    chk("t2_busy", {31'd0, busy_o[0]}, 32'd0);
    chk("t2_timing", 32'(err_n - last_run_n), 32'(TIMEOUT + 1));
    done_delay = 3;
    pulse_start();
    chk("t2_restart_err", {31'd0, error_o[0]}, 32'd0);
    chk("t2_restart_addr", 32'(mem_addr_o[0]), 32'd0);
    wait_idle("t2_idle2", 200);

    // Step mode: one run per step, extra step during WAIT_DONE ignored.
    step_mode = 1'b1; done_delay = 5; runs0 = 0;
    pulse_start();
    cyc(6);
    chk("t4_no_run", 32'(runs0), 32'd0);
    chk("t4_busy", {31'd0, busy_o[0]}, 32'd1);
    pulse_step();
    cyc(4);
    pulse_step();
    cyc(10);
    chk("t4_runs1", 32'(runs0), 32'd1);
    chk("t4_count1", 32'(icnt_o[0]), 32'd1);
    chk("t4_addr1", 32'(mem_addr_o[0]), 32'd1);
    pulse_step();
    cyc(15);
    chk("t4_runs2", 32'(runs0), 32'd2);
    chk("t4_count2", 32'(icnt_o[0]), 32'd2);
    pulse_step();
    wait_idle("t4_idle", 20);
    chk("t4_halted", {31'd0, halted_o[0]}, 32'd1);
    step_mode = 1'b0;

    // Done arriving on the timeout edge still advances.
    done_delay = TIMEOUT;
    pulse_start();
    wait_idle("t6a_idle", 200);
    chk("t6a_error", {31'd0, error_o[0]}, 32'd0);
    chk("t6a_count", 32'(icnt_o[0]), 32'd2);

    // Start while busy has no effect.
    done_delay = 6; runs0 = 0;
    pulse_start();
    n = 0;
    while (runs0 < 1 && n < 20) begin cyc(1); n++; end
    chk("t6b_first_run", 32'(runs0), 32'd1);
    pulse_start();
    cyc(2);
    chk("t6b_addr", 32'(mem_addr_o[0]), 32'd0);
    chk("t6b_count", 32'(icnt_o[0]), 32'd0);
    chk("t6b_busy", {31'd0, busy_o[0]}, 32'd1);
    wait_idle("t6b_idle", 200);
    chk("t6b_final", 32'(icnt_o[0]), 32'd2);

    // End of memory: WRAP=0 halts at 31, WRAP=1 issues word[0] again.
    for (int k = 0; k < DEPTH; k++) mem[k] = 16'h0100 + 16'(k);
    done_delay = 1; runs0 = 0; runs1 = 0;
    pulse_start();
    wait_idle("t3_idle", 400);
    chk("t3_halted", {31'd0, halted_o[0]}, 32'd1);
    chk("t3_count", 32'(icnt_o[0]), 32'd32);
    chk("t3_addr", 32'(mem_addr_o[0]), 32'd31);
    chk("t3_runs", 32'(runs0), 32'd32);
    n = 0;
    while (runs1 < 33 && n < 50) begin cyc(1); n++; end
    chk("t3_wrap_runs", 32'(runs1), 32'd33);
    chk("t3_wrap_din", 32'(last_din1), 32'h0100);
    chk("t3_wrap_busy", {31'd0, busy_o[1]}, 32'd1);

    // Asynchronous reset mid-instruction.
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t5_run", {31'd0, run_o[1]}, 32'd0);
    chk("t5_busy", {31'd0, busy_o[1]}, 32'd0);
    chk("t5_din", 32'(din_o[1]), 32'd0);
    chk("t5_count", 32'(icnt_o[1]), 32'd0);
    chk("t5_halted", {31'd0, halted_o[0]}, 32'd0);
    chk("t5_addr0", 32'(mem_addr_o[0]), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    runs0 = 0; runs1 = 0;
    cyc(8);
    chk("t5_no_run0", 32'(runs0), 32'd0);
    chk("t5_no_run1", 32'(runs1), 32'd0);
    chk("t5_idle", {31'd0, busy_o[1]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
